// File: rtl/awg_pkg.sv
// Shared types and constants for the arbitrary-waveform sequencer.
// Holds the FSM encoding, prefetch depth and the "play forever" loop count.
package awg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } awg_state_e;

    localparam int unsigned BUF_DEPTH      = 2;
    localparam logic [15:0] LOOPS_INFINITE = 16'd0;

endpackage

// File: rtl/awg_prefetch_buf.sv
// Two-entry sample buffer between the sample memory and the AXI-Stream output.
// slot0 is always the head, so the output data only moves on a pop.
module awg_prefetch_buf
    import awg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         empty_o
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;
    logic         push_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != FULL) || pop_ok);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush_i) begin
            slot0_d = '0;
            slot1_d = '0;
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = push_data_i;
                    else                 slot1_d = push_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_d = push_data_i;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/awg_sequencer.sv
// Plays a looped segment of sample memory onto an AXI-Stream output after a trigger edge.
// Handshake: a sample transfers on a cycle where out_tvalid and out_tready are both 1; out_tdata is held while stalled.
module awg_sequencer
    import awg_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk100,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_length,
    input  logic [15:0]           cfg_loops,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  ext_trigger,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BIT_WIDTH-1:0]  mem_rd_data,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [BIT_WIDTH-1:0]  out_tdata,
    output logic                  trigger_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           loop_cnt,
    output awg_state_e            dbg_state_o
);

    localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
    localparam logic [15:0]           ONE_16 = 16'd1;

    awg_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [15:0]           loops_q, loops_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [15:0]           rd_segs_q, rd_segs_d;
    logic [ADDR_WIDTH-1:0] hs_idx_q, hs_idx_d;
    logic [15:0]           loop_cnt_q, loop_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  trig_prev_q, trig_prev_d;
    logic                  error_q, error_d;

    logic                  trig_edge;
    logic                  arm_ok;
    logic                  arm_bad;
    logic                  abort_act;
    logic                  fetching;
    logic                  reads_left;
    logic                  handshake;
    logic                  final_hs;
    logic                  rd_en;
    logic [2:0]            pending;
    logic [1:0]            buf_count;
    logic                  buf_empty;
    logic [BIT_WIDTH-1:0]  buf_head;

    assign trig_edge  = ext_trigger && !trig_prev_q;
    assign arm_ok     = (state_q == ST_IDLE) && arm && !abort && (cfg_length != '0);
    assign arm_bad    = (state_q == ST_IDLE) && arm && !abort && (cfg_length == '0);
    assign abort_act  = abort && (state_q != ST_IDLE);
    assign fetching   = (state_q == ST_ARMED) || (state_q == ST_PLAY);
    assign reads_left = (loops_q == LOOPS_INFINITE) || (rd_segs_q != loops_q);
    assign handshake  = out_tvalid && out_tready;
    assign final_hs   = handshake && (loops_q != LOOPS_INFINITE)
                        && (hs_idx_q == len_q - ONE_A) && (loop_cnt_q == loops_q - ONE_16);

    // Occupancy counts the slot freed by this cycle's pop, which keeps reads back-to-back at full rate.
    assign pending = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, handshake};
    assign rd_en   = !rst && fetching && reads_left && !abort && (pending < 3'(BUF_DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arm_ok) state_d = ST_ARMED;
            ST_ARMED: begin
                if (abort)          state_d = ST_IDLE;
                else if (trig_edge) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (abort)         state_d = ST_IDLE;
                else if (final_hs) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_d     = start_q;
        len_d       = len_q;
        loops_d     = loops_q;
        addr_d      = addr_q;
        rd_idx_d    = rd_idx_q;
        rd_segs_d   = rd_segs_q;
        hs_idx_d    = hs_idx_q;
        loop_cnt_d  = loop_cnt_q;
        inflight_d  = rd_en;
        error_d     = arm_bad;
        trig_prev_d = ext_trigger;
        if (arm_ok) begin
            start_d    = cfg_start_addr;
            len_d      = cfg_length;
            loops_d    = cfg_loops;
            addr_d     = cfg_start_addr;
            rd_idx_d   = '0;
            rd_segs_d  = '0;
            hs_idx_d   = '0;
            loop_cnt_d = '0;
        end else begin
            if (rd_en) begin
                if (rd_idx_q == len_q - ONE_A) begin
                    rd_idx_d  = '0;
                    addr_d    = start_q;
                    rd_segs_d = rd_segs_q + ONE_16;
                end else begin
                    rd_idx_d = rd_idx_q + ONE_A;
                    addr_d   = addr_q + ONE_A;
                end
            end
            if (handshake && !abort_act) begin
                if (hs_idx_q == len_q - ONE_A) begin
                    hs_idx_d = '0;
                    if (loop_cnt_q != 16'hFFFF) loop_cnt_d = loop_cnt_q + ONE_16;
                end else begin
                    hs_idx_d = hs_idx_q + ONE_A;
                end
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            start_q     <= '0;
            len_q       <= '0;
            loops_q     <= '0;
            addr_q      <= '0;
            rd_idx_q    <= '0;
            rd_segs_q   <= '0;
            hs_idx_q    <= '0;
            loop_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            trig_prev_q <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            len_q       <= len_d;
            loops_q     <= loops_d;
            addr_q      <= addr_d;
            rd_idx_q    <= rd_idx_d;
            rd_segs_q   <= rd_segs_d;
            hs_idx_q    <= hs_idx_d;
            loop_cnt_q  <= loop_cnt_d;
            inflight_q  <= inflight_d;
            trig_prev_q <= trig_prev_d;
            error_q     <= error_d;
        end
    end

    // Flushing on abort also drops the read returning this cycle; none is issued during abort.
    awg_prefetch_buf #(
        .W(BIT_WIDTH)
    ) u_buf (
        .clk        (clk100),
        .rst        (rst),
        .flush_i    (abort_act),
        .push_i     (inflight_q),
        .push_data_i(mem_rd_data),
        .pop_i      (handshake),
        .head_o     (buf_head),
        .count_o    (buf_count),
        .empty_o    (buf_empty)
    );

    assign mem_rd_en   = rd_en;
    assign mem_addr    = addr_q;
    assign out_tvalid  = (state_q == ST_PLAY) && !buf_empty;
    assign out_tdata   = buf_head;
    assign trigger_out = (state_q == ST_PLAY);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign error       = error_q;
    assign loop_cnt    = loop_cnt_q;
    assign dbg_state_o = state_q;

endmodule
